// File: rtl/axid_tracker_pkg.sv
// Shared width helpers for the AXI ID tracker and the R/B response handlers.
// Slot-count, pointer and outstanding-count widths all derive from here.
package axid_tracker_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int ptr_w(input int depth);
    return clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic int outstanding_w(input int num_slots, input int depth);
    return clog2(num_slots * depth + 1);
  endfunction

endpackage

// File: rtl/axid_slot_fifo.sv
// Per-slot descriptor FIFO with the head word visible before it is popped.
// Push into a full FIFO is legal only together with a pop; the caller guarantees that.
module axid_slot_fifo
  import axid_tracker_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [WIDTH-1:0]        i_din,
  output logic [WIDTH-1:0]        o_dout_pre,
  output logic                    o_empty,
  output logic                    o_full,
  output logic [cnt_w(DEPTH)-1:0] o_count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (i_push && !i_pop)      r_count <= r_count + CNT_ONE;
      else if (i_pop && !i_push) r_count <= r_count - CNT_ONE;
    end
  end

  assign o_dout_pre = r_mem[r_rd_ptr];
  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CNT_FULL);
  assign o_count    = r_count;

endmodule

// File: rtl/axid_tracker.sv
// Maps each accepted AXI address beat to its issuing descriptor, queued per AXI ID,
// and hands the owning descriptor back on each response beat in same-ID order.
module axid_tracker
  import axid_tracker_pkg::*;
#(
  parameter int NUM_SLOTS     = 16,
  parameter int SLOT_DEPTH    = 16,
  parameter int AXI_ID_WIDTH  = 4,
  parameter int DESC_ID_WIDTH = 4
) (
  input  logic                                          axi_aclk,
  input  logic                                          axi_areset,
  input  logic                                          req_valid,
  output logic                                          req_ready,
  input  logic [AXI_ID_WIDTH-1:0]                       req_axid,
  input  logic [DESC_ID_WIDTH-1:0]                      req_desc_id,
  input  logic                                          rsp_valid,
  input  logic                                          rsp_ready,
  input  logic                                          rsp_last,
  input  logic [AXI_ID_WIDTH-1:0]                       rsp_axid,
  output logic                                          rsp_hit,
  output logic [DESC_ID_WIDTH-1:0]                      rsp_desc_id,
  output logic                                          rsp_err,
  output logic [NUM_SLOTS-1:0]                          slot_valid,
  output logic [outstanding_w(NUM_SLOTS, SLOT_DEPTH)-1:0] outstanding,
  output logic                                          idle
);

  localparam int CW = cnt_w(SLOT_DEPTH);
  localparam int OW = outstanding_w(NUM_SLOTS, SLOT_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [OW-1:0] OUT_ONE = OW'(1);

  logic [NUM_SLOTS-1:0]     r_valid;
  logic [AXI_ID_WIDTH-1:0]  r_id [NUM_SLOTS];
  logic [OW-1:0]            r_outstanding;
  logic                     r_rsp_err;

  logic [NUM_SLOTS-1:0]     w_req_match;
  logic [NUM_SLOTS-1:0]     w_rsp_match;
  logic [NUM_SLOTS-1:0]     w_alloc;
  logic [NUM_SLOTS-1:0]     w_full;
  logic [NUM_SLOTS-1:0]     w_slot_push;
  logic [NUM_SLOTS-1:0]     w_slot_pop;
  logic [DESC_ID_WIDTH-1:0] w_head [NUM_SLOTS];
  logic [CW-1:0]            w_count [NUM_SLOTS];
  logic                     w_any_req_match;
  logic                     w_found_free;
  logic                     w_req_ready;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_hit;
  logic [DESC_ID_WIDTH-1:0] w_desc;

  always_comb begin
    w_req_match  = '0;
    w_rsp_match  = '0;
    w_alloc      = '0;
    w_found_free = 1'b0;
    w_desc       = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      w_req_match[k] = r_valid[k] && (r_id[k] == req_axid);
      w_rsp_match[k] = r_valid[k] && (r_id[k] == rsp_axid);
      if (w_rsp_match[k]) w_desc = w_desc | w_head[k];
      // Lowest-index free slot wins; uses the pre-edge valid map.
      if (!r_valid[k] && !w_found_free) begin
        w_alloc[k]   = 1'b1;
        w_found_free = 1'b1;
      end
    end
  end

  assign w_any_req_match = |w_req_match;
  assign w_hit           = |w_rsp_match;
  assign w_req_ready     = w_any_req_match ? ~|(w_req_match & w_full) : w_found_free;
  assign w_pop           = rsp_valid && rsp_ready && rsp_last && w_hit;
  assign w_slot_pop      = w_pop ? w_rsp_match : '0;

  // A full matched slot still takes the push when it pops the same cycle.
  assign w_push      = req_valid &&
                       (w_req_ready || (w_any_req_match && |(w_req_match & w_slot_pop)));
  assign w_slot_push = !w_push ? '0 : (w_any_req_match ? w_req_match : w_alloc);

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    axid_slot_fifo #(
      .DEPTH (SLOT_DEPTH),
      .WIDTH (DESC_ID_WIDTH)
    ) u_fifo (
      .clk        (axi_aclk),
      .rst        (axi_areset),
      .i_push     (w_slot_push[g]),
      .i_pop      (w_slot_pop[g]),
      .i_din      (req_desc_id),
      .o_dout_pre (w_head[g]),
      .o_empty    (),
      .o_full     (w_full[g]),
      .o_count    (w_count[g])
    );
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      r_valid <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) r_id[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (w_slot_push[k]) begin
          r_valid[k] <= 1'b1;
          if (!r_valid[k]) r_id[k] <= req_axid;
        end else if (w_slot_pop[k] && (w_count[k] == CNT_ONE)) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      r_outstanding <= '0;
      r_rsp_err     <= 1'b0;
    end else begin
      if (w_push && !w_pop)      r_outstanding <= r_outstanding + OUT_ONE;
      else if (w_pop && !w_push) r_outstanding <= r_outstanding - OUT_ONE;
      r_rsp_err <= rsp_valid && rsp_ready && !w_hit;
    end
  end

  assign req_ready   = w_req_ready;
  assign rsp_hit     = w_hit;
  assign rsp_desc_id = w_desc;
  assign rsp_err     = r_rsp_err;
  assign slot_valid  = r_valid;
  assign outstanding = r_outstanding;
  assign idle        = (r_outstanding == '0);

endmodule

// File: tb/tb_axid_tracker.sv
// Directed bench for axid_tracker: 8 slots of depth 4, 4-bit AXI IDs and descriptors.
module tb_axid_tracker;

  localparam int NS = 8;
  localparam int SD = 4;
  localparam int AW = 4;
  localparam int DW = 4;
  localparam int OW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_axid;
  logic [DW-1:0] req_desc_id;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_last;
  logic [AW-1:0] rsp_axid;
  logic          rsp_hit;
  logic [DW-1:0] rsp_desc_id;
  logic          rsp_err;
  logic [NS-1:0] slot_valid;
  logic [OW-1:0] outstanding;
  logic          idle;

  int n_tests = 0;
  int n_fail  = 0;

  axid_tracker #(
    .NUM_SLOTS     (NS),
    .SLOT_DEPTH    (SD),
    .AXI_ID_WIDTH  (AW),
    .DESC_ID_WIDTH (DW)
  ) dut (
    .axi_aclk    (clk),
    .axi_areset  (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_axid    (req_axid),
    .req_desc_id (req_desc_id),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_last    (rsp_last),
    .rsp_axid    (rsp_axid),
    .rsp_hit     (rsp_hit),
    .rsp_desc_id (rsp_desc_id),
    .rsp_err     (rsp_err),
    .slot_valid  (slot_valid),
    .outstanding (outstanding),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one edge; inputs are then driven and checked 1-2 ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    req_valid = 1'b0; req_axid = '0; req_desc_id = '0;
    rsp_valid = 1'b0; rsp_ready = 1'b0; rsp_last = 1'b0; rsp_axid = '0;
  endtask

  task automatic push(input logic [AW-1:0] id, input logic [DW-1:0] d);
    req_valid = 1'b1; req_axid = id; req_desc_id = d;
  endtask

  task automatic beat(input logic [AW-1:0] id, input logic last);
    rsp_valid = 1'b1; rsp_ready = 1'b1; rsp_axid = id; rsp_last = last;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b exp 1", idle); end
    n_tests++; if (outstanding !== 6'd0) begin n_fail++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
    n_tests++; if (slot_valid !== 8'h00) begin n_fail++; $display("FAIL reset_slot_valid got %h exp 00", slot_valid); end
    n_tests++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    n_tests++; if (rsp_hit !== 1'b0 || rsp_desc_id !== 4'd0) begin n_fail++; $display("FAIL reset_lookup got hit=%b desc=%0d exp 0/0", rsp_hit, rsp_desc_id); end
  endtask

  task automatic test_single_push();
    push(4'd3, 4'd5);
    rsp_axid = 4'd3;
    #1;
    n_tests++; if (rsp_hit !== 1'b0) begin n_fail++; $display("FAIL same_cycle_miss got hit=%b exp 0", rsp_hit); end
    cyc();
    drive_idle(); rsp_axid = 4'd3;
    #1;
    n_tests++; if (slot_valid !== 8'h01) begin n_fail++; $display("FAIL single_slot_valid got %h exp 01", slot_valid); end
    n_tests++; if (rsp_hit !== 1'b1 || rsp_desc_id !== 4'd5) begin n_fail++; $display("FAIL single_lookup got hit=%b desc=%0d exp 1/5", rsp_hit, rsp_desc_id); end
    n_tests++; if (outstanding !== 6'd1) begin n_fail++; $display("FAIL single_outstanding got %0d exp 1", outstanding); end
    beat(4'd3, 1'b1);
    cyc();
    drive_idle(); #1;
    n_tests++; if (slot_valid !== 8'h00 || idle !== 1'b1) begin n_fail++; $display("FAIL single_release got sv=%h idle=%b exp 00/1", slot_valid, idle); end
  endtask

  task automatic test_multi_beat();
    logic [DW-1:0] exp_desc [3];
    exp_desc[0] = 4'd1; exp_desc[1] = 4'd4; exp_desc[2] = 4'd7;
    for (int i = 0; i < 3; i++) begin
      push(4'd2, exp_desc[i]);
      cyc();
    end
    drive_idle(); #1;
    n_tests++; if (outstanding !== 6'd3) begin n_fail++; $display("FAIL multi_outstanding got %0d exp 3", outstanding); end
    for (int b = 0; b < 6; b++) begin
      beat(4'd2, (b % 2) == 1);
      #1;
      n_tests++; if (rsp_desc_id !== exp_desc[b/2] || rsp_hit !== 1'b1) begin n_fail++; $display("FAIL multi_beat%0d got hit=%b desc=%0d exp 1/%0d", b, rsp_hit, rsp_desc_id, exp_desc[b/2]); end
      n_tests++; if (slot_valid !== 8'h01) begin n_fail++; $display("FAIL multi_valid%0d got %h exp 01", b, slot_valid); end
      cyc();
    end
    drive_idle(); #1;
    n_tests++; if (slot_valid !== 8'h00 || idle !== 1'b1) begin n_fail++; $display("FAIL multi_freed got sv=%h idle=%b exp 00/1", slot_valid, idle); end
  endtask

  task automatic test_alloc_full();
    logic [AW-1:0] ids [8];
    for (int i = 0; i < NS; i++) begin
      push(AW'(i), DW'(i));
      cyc();
    end
    drive_idle(); req_axid = 4'd9; #1;
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL all_slots_ready got %b exp 0", req_ready); end
    n_tests++; if (slot_valid !== 8'hFF || outstanding !== 6'd8) begin n_fail++; $display("FAIL all_slots_state got sv=%h out=%0d exp FF/8", slot_valid, outstanding); end
    beat(4'd4, 1'b1); #1;
    n_tests++; if (rsp_desc_id !== 4'd4) begin n_fail++; $display("FAIL pop_id4_desc got %0d exp 4", rsp_desc_id); end
    cyc();
    drive_idle(); push(4'd9, 4'd9); #1;
    n_tests++; if (slot_valid !== 8'hEF || req_ready !== 1'b1) begin n_fail++; $display("FAIL slot4_freed got sv=%h ready=%b exp EF/1", slot_valid, req_ready); end
    cyc();
    drive_idle(); rsp_axid = 4'd9; #1;
    n_tests++; if (slot_valid !== 8'hFF || rsp_hit !== 1'b1 || rsp_desc_id !== 4'd9) begin n_fail++; $display("FAIL id9_in_slot4 got sv=%h hit=%b desc=%0d exp FF/1/9", slot_valid, rsp_hit, rsp_desc_id); end
    ids[0] = 4'd0; ids[1] = 4'd1; ids[2] = 4'd2; ids[3] = 4'd3;
    ids[4] = 4'd9; ids[5] = 4'd5; ids[6] = 4'd6; ids[7] = 4'd7;
    for (int i = 0; i < NS; i++) begin
      beat(ids[i], 1'b1);
      cyc();
    end
    drive_idle(); #1;
    n_tests++; if (idle !== 1'b1 || slot_valid !== 8'h00) begin n_fail++; $display("FAIL alloc_drain got idle=%b sv=%h exp 1/00", idle, slot_valid); end
  endtask

  task automatic test_slot_full();
    logic [DW-1:0] exp_desc [4];
    for (int i = 0; i < SD; i++) begin
      push(4'd1, DW'(i));
      cyc();
    end
    drive_idle(); req_axid = 4'd1; #1;
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_id1 got %b exp 0", req_ready); end
    req_axid = 4'd12; #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_other got %b exp 1", req_ready); end
    beat(4'd1, 1'b1);
    cyc();
    drive_idle(); req_axid = 4'd1; #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_pop got %b exp 1", req_ready); end
    push(4'd1, 4'd8);
    cyc();
    // Full slot: push rides on a same-cycle pop even though ready is low.
    push(4'd1, 4'd9); beat(4'd1, 1'b1); #1;
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_ready got %b exp 0", req_ready); end
    cyc();
    drive_idle(); #1;
    n_tests++; if (outstanding !== 6'd4) begin n_fail++; $display("FAIL full_pushpop_out got %0d exp 4", outstanding); end
    exp_desc[0] = 4'd2; exp_desc[1] = 4'd3; exp_desc[2] = 4'd8; exp_desc[3] = 4'd9;
    for (int i = 0; i < 4; i++) begin
      beat(4'd1, 1'b1); #1;
      n_tests++; if (rsp_desc_id !== exp_desc[i]) begin n_fail++; $display("FAIL full_order%0d got %0d exp %0d", i, rsp_desc_id, exp_desc[i]); end
      cyc();
    end
    drive_idle(); #1;
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL full_drain got idle=%b exp 1", idle); end
  endtask

  task automatic test_unknown_id();
    push(4'd3, 4'd2);
    cyc();
    drive_idle(); beat(4'd6, 1'b1); #1;
    n_tests++; if (rsp_hit !== 1'b0 || rsp_desc_id !== 4'd0) begin n_fail++; $display("FAIL miss_lookup got hit=%b desc=%0d exp 0/0", rsp_hit, rsp_desc_id); end
    n_tests++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL err_early got %b exp 0", rsp_err); end
    cyc();
    drive_idle(); #1;
    n_tests++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL err_pulse got %b exp 1", rsp_err); end
    n_tests++; if (outstanding !== 6'd1 || slot_valid !== 8'h01) begin n_fail++; $display("FAIL err_state got out=%0d sv=%h exp 1/01", outstanding, slot_valid); end
    cyc();
    n_tests++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL err_width got %b exp 0", rsp_err); end
    beat(4'd3, 1'b1);
    cyc();
    drive_idle(); #1;
  endtask

  task automatic test_pop_push_same();
    push(4'd2, 4'd3);
    cyc();
    push(4'd2, 4'd6); beat(4'd2, 1'b1); #1;
    n_tests++; if (rsp_desc_id !== 4'd3) begin n_fail++; $display("FAIL pp_head got %0d exp 3", rsp_desc_id); end
    cyc();
    drive_idle(); rsp_axid = 4'd2; #1;
    n_tests++; if (slot_valid !== 8'h01 || outstanding !== 6'd1) begin n_fail++; $display("FAIL pp_state got sv=%h out=%0d exp 01/1", slot_valid, outstanding); end
    n_tests++; if (rsp_hit !== 1'b1 || rsp_desc_id !== 4'd6) begin n_fail++; $display("FAIL pp_new_head got hit=%b desc=%0d exp 1/6", rsp_hit, rsp_desc_id); end
  endtask

  task automatic test_reset_mid();
    push(4'd5, 4'd1);
    cyc();
    push(4'd7, 4'd2); beat(4'd11, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0; drive_idle(); rsp_axid = 4'd2; #1;
    n_tests++; if (slot_valid !== 8'h00 || outstanding !== 6'd0 || idle !== 1'b1) begin n_fail++; $display("FAIL mid_reset_state got sv=%h out=%0d idle=%b exp 00/0/1", slot_valid, outstanding, idle); end
    n_tests++; if (rsp_err !== 1'b0 || rsp_hit !== 1'b0 || rsp_desc_id !== 4'd0) begin n_fail++; $display("FAIL mid_reset_rsp got err=%b hit=%b desc=%0d exp 0/0/0", rsp_err, rsp_hit, rsp_desc_id); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready got %b exp 1", req_ready); end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_single_push();
    test_multi_beat();
    test_alloc_full();
    test_slot_full();
    test_unknown_id();
    test_pop_push_same();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
